axil_led_sequencer: RTL and testbench

//  AXI-Lite master that drives the LED register slave (LED reg at LED_ADDR, byte 0) with a timed pattern sequence.

---
 rtl/led_seq_pkg.sv | 37 +++
 rtl/led_seq_tick_gen.sv | 46 ++++
 rtl/axil_led_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_axil_led_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the AXI-Lite LED sequencer: FSM states, pattern
// modes, AXI response codes and the pattern-advance helper.
package led_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WRESP,
    ST_RD,
    ST_RRESP
  } state_e;

  typedef enum logic [1:0] {
    MODE_WALK   = 2'b00,
    MODE_COUNT  = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [15:0] LED_ADDR_DEFAULT = 16'h0000;
  localparam logic [7:0]  PAT_RESET        = 8'h01;

  // Pattern that follows `pat` under the given mode
  function automatic logic [7:0] next_pat(input logic [1:0] mode, input logic [7:0] pat);
    logic [7:0] r;
    r = pat;
    case (mode)
      MODE_WALK:   r = {pat[6:0], pat[7]};
      MODE_COUNT:  r = pat + 8'd1;
      MODE_TOGGLE: r = pat ^ 8'hFF;
      default:     r = pat;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_seq_tick_gen.sv
// Step timer for the LED sequencer. Produces a tick every max(period,1)
// cycles while enabled, remembers one tick that lands while a step is in
// flight, and flags a tick that has nowhere to go.
//   clk, rst_n   clock, synchronous active-low reset
//   enable       run the timer; low clears timer and pending
//   period       cycles between ticks (0 behaves as 1)
//   fsm_busy     sequencer is mid-step
//   consume      sequencer is starting the pending step this cycle
//   tick_c       tick this cycle (from registered count)
//   pending      one tick waiting for the current step to finish
//   overrun_c    tick dropped because one was already pending
module led_seq_tick_gen #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                fsm_busy,
  input  logic                consume,
  output logic                tick_c,
  output logic                pending,
  output logic                overrun_c
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] last_c;

  // >= keeps the timer from running the full counter range if period shrinks
  assign last_c    = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign tick_c    = enable && (count >= last_c);
  assign overrun_c = tick_c && fsm_busy && pending && !consume;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      count   <= '0;
      pending <= 1'b0;
    end else begin
      count <= tick_c ? '0 : count + PERIOD_W'(1);
      // a tick landing as the old one is consumed becomes the new pending one
      if (tick_c && fsm_busy) pending <= 1'b1;
      else if (consume)       pending <= 1'b0;
    end
  end

endmodule

// File: rtl/axil_led_sequencer.sv
// AXI-Lite master that walks an 8-bit pattern through the LED register:
// each step writes the next pattern, reads it back and checks data and
// responses. Mismatches, stalled handshakes and overrun ticks raise sticky
// error flags.
//   axi_aclk, axi_aresetn   clock, synchronous active-low reset
//   enable, mode, period    sequence control
//   err_clr                 clear sticky flags (a same-cycle set wins)
//   busy, step_cnt          status
//   err_mismatch/timeout/overrun  sticky error flags
//   m_axil_*                AXI-Lite master port (AW, W, B, AR, R)
module axil_led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [15:0] LED_ADDR   = LED_ADDR_DEFAULT,
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [PERIOD_W-1:0]   period,
  input  logic                  err_clr,
  output logic                  busy,
  output logic [15:0]           step_cnt,
  output logic                  err_mismatch,
  output logic                  err_timeout,
  output logic                  err_overrun,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  state_e          state, state_n;
  logic [7:0]      pat, pat_n;
  logic [15:0]     step_n;
  logic [1:0]      bresp_q, bresp_n;
  logic [WD_W-1:0] wd_cnt, wd_n;
  logic            awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n, busy_n;
  logic            start_c, done_c, mismatch_set_c, timeout_set_c;
  logic            tick_c, pending, overrun_c, consume_c;
  logic            unused_rdata;

  assign m_axil_awaddr = ADDR_WIDTH'(LED_ADDR);
  assign m_axil_araddr = ADDR_WIDTH'(LED_ADDR);
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;
  assign m_axil_wstrb  = STRB_WIDTH'(1);
  assign m_axil_wdata  = DATA_WIDTH'(pat);
  assign unused_rdata  = ^m_axil_rdata;
  assign consume_c     = done_c && pending;

  led_seq_tick_gen #(.PERIOD_W(PERIOD_W)) u_tick (
    .clk       (axi_aclk),
    .rst_n     (axi_aresetn),
    .enable    (enable),
    .period    (period),
    .fsm_busy  (state != ST_IDLE),
    .consume   (consume_c),
    .tick_c    (tick_c),
    .pending   (pending),
    .overrun_c (overrun_c)
  );

  // Next-state, next-output and step bookkeeping
  always_comb begin
    state_n        = state;
    pat_n          = pat;
    step_n         = step_cnt;
    bresp_n        = bresp_q;
    awvalid_n      = m_axil_awvalid;
    wvalid_n       = m_axil_wvalid;
    bready_n       = m_axil_bready;
    arvalid_n      = m_axil_arvalid;
    rready_n       = m_axil_rready;
    start_c        = 1'b0;
    done_c         = 1'b0;
    mismatch_set_c = 1'b0;

    case (state)
      ST_IDLE: start_c = tick_c;
      ST_WR: begin
        // AW and W retire independently; move on once both are gone
        awvalid_n = m_axil_awvalid && !m_axil_awready;
        wvalid_n  = m_axil_wvalid && !m_axil_wready;
        if (!awvalid_n && !wvalid_n) begin
          state_n  = ST_WRESP;
          bready_n = 1'b1;
        end
      end
      ST_WRESP: begin
        if (m_axil_bvalid && m_axil_bready) begin
          bresp_n   = m_axil_bresp;
          bready_n  = 1'b0;
          arvalid_n = 1'b1;
          state_n   = ST_RD;
        end
      end
      ST_RD: begin
        if (m_axil_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = ST_RRESP;
        end
      end
      ST_RRESP: begin
        if (m_axil_rvalid && m_axil_rready) begin
          rready_n       = 1'b0;
          done_c         = 1'b1;
          step_n         = step_cnt + 16'd1;
          mismatch_set_c = (m_axil_rdata[7:0] != pat) || (m_axil_rresp != RESP_OKAY)
                           || (bresp_q != RESP_OKAY);
          if (pending) start_c = 1'b1;
          else         state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // pat holds the pattern of the step in flight (or the last one)
    if (start_c) begin
      state_n   = ST_WR;
      awvalid_n = 1'b1;
      wvalid_n  = 1'b1;
      pat_n     = next_pat(mode, pat);
    end

    busy_n = (state_n != ST_IDLE);
  end

  // Per-state stall counter; restarts on every state change
  always_comb begin
    wd_n          = '0;
    timeout_set_c = 1'b0;
    if (state != ST_IDLE && state_n == state) begin
      wd_n          = (wd_cnt == WD_W'(TIMEOUT)) ? wd_cnt : wd_cnt + WD_W'(1);
      timeout_set_c = (wd_cnt == WD_W'(TIMEOUT - 1));
    end
  end

  // State and registered outputs
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state          <= ST_IDLE;
      pat            <= PAT_RESET;
      step_cnt       <= '0;
      bresp_q        <= RESP_OKAY;
      wd_cnt         <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      busy           <= 1'b0;
      err_mismatch   <= 1'b0;
      err_timeout    <= 1'b0;
      err_overrun    <= 1'b0;
    end else begin
      state          <= state_n;
      pat            <= pat_n;
      step_cnt       <= step_n;
      bresp_q        <= bresp_n;
      wd_cnt         <= wd_n;
      m_axil_awvalid <= awvalid_n;
      m_axil_wvalid  <= wvalid_n;
      m_axil_bready  <= bready_n;
      m_axil_arvalid <= arvalid_n;
      m_axil_rready  <= rready_n;
      busy           <= busy_n;
      err_mismatch   <= mismatch_set_c | (err_mismatch & ~err_clr);
      err_timeout    <= timeout_set_c  | (err_timeout  & ~err_clr);
      err_overrun    <= overrun_c      | (err_overrun  & ~err_clr);
    end
  end

endmodule

// File: tb/tb_axil_led_sequencer.sv
// Bench for axil_led_sequencer: a small LED-register slave model with
// knobs for AW delay, AR stall and a one-shot readback corruption; expected
// write patterns and status checks are queued and compared by a monitor.
`timescale 1ns/1ps
module tb_axil_led_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, err_clr;
  logic [1:0]  mode;
  logic [23:0] period;
  logic        busy, err_mismatch, err_timeout, err_overrun;
  logic [15:0] step_cnt;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axil_led_sequencer dut (
    .axi_aclk(clk), .axi_aresetn(rst_n), .enable(enable), .mode(mode), .period(period),
    .err_clr(err_clr), .busy(busy), .step_cnt(step_cnt), .err_mismatch(err_mismatch),
    .err_timeout(err_timeout), .err_overrun(err_overrun),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  // ---------------- slave model ----------------
  int unsigned aw_delay;
  bit          ar_block, corrupt_once;
  int unsigned aw_cnt;
  logic        got_aw, got_w;
  logic [7:0]  led_reg;
  logic        aw_hs, w_hs;

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = 1'b1;
  assign arready = arvalid && !ar_block;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign bresp   = 2'b00;
  assign rresp   = 2'b00;

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0; bvalid <= 1'b0;
      rvalid <= 1'b0; rdata <= '0; led_reg <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      if (w_hs) led_reg <= wdata[7:0];
      if ((got_aw || aw_hs) && (got_w || w_hs) && !bvalid) begin
        bvalid <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
      end else begin
        if (aw_hs) got_aw <= 1'b1;
        if (w_hs)  got_w  <= 1'b1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arready) begin
        rvalid <= 1'b1;
        rdata  <= {24'h0, corrupt_once ? (led_reg ^ 8'h01) : led_reg};
      end else if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  chk_t       chk_q[$];
  logic [7:0] exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic req(input string nm, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    c.name = nm; c.act = a; c.exp = e;
    chk_q.push_back(c);
  endtask

  // Monitor: W beats against the expected-pattern queue, plus queued status checks
  always @(negedge clk) begin
    chk_t       c;
    logic [7:0] e;
    if (aw_hs) begin
      n_chk++;
      if (awaddr != 16'h0000 || awprot != 3'b000) begin
        n_fail++;
        $display("FAIL aw_attr: got addr=%h prot=%0d, required addr=0000 prot=0", awaddr, awprot);
      end
    end
    if (w_hs) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wdata_unexpected: got %h, required no write", wdata);
      end else begin
        e = exp_q.pop_front();
        if (wdata != {24'h0, e} || wstrb != 4'b0001) begin
          n_fail++;
          $display("FAIL wdata: got %h strb %b, required %h strb 0001", wdata, wstrb, {24'h0, e});
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      n_chk++;
      if (c.act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h, required %0h", c.name, c.act, c.exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int unsigned which);
    case (which)
      0:       return awvalid;
      1:       return bready;
      2:       return arvalid;
      default: return rvalid && rready;
    endcase
  endfunction

  task automatic wait_until(input int unsigned which, input int unsigned budget,
                            input string nm, output int unsigned n);
    n = 0;
    while (!sig(which) && n < budget) begin tick1(); n++; end
    if (!sig(which)) req(nm, 32'(0), 32'(1));
  endtask

  task automatic wait_steps(input int unsigned target, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (step_cnt != 16'(target) && n < budget) begin tick1(); n++; end
    if (step_cnt != 16'(target)) req("step_wait", 32'(step_cnt), 32'(target));
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; tick1(); err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int unsigned n, na, nw, nb;
    logic [7:0]  p;
    rst_n = 1'b0; enable = 1'b0; mode = 2'b00; period = 24'd10; err_clr = 1'b0;
    aw_delay = 0; ar_block = 1'b0; corrupt_once = 1'b0;
    repeat (3) tick1();
    req("rst_handshake", 32'({awvalid, wvalid, bready, arvalid, rready, busy}), 32'(0));
    req("rst_step", 32'(step_cnt), 32'(0));
    req("rst_err", 32'({err_mismatch, err_timeout, err_overrun}), 32'(0));
    rst_n = 1'b1;
    tick1();

    // 1: walking one, 8 steps ending back at 01
    p = 8'h01;
    for (int i = 0; i < 8; i++) begin p = {p[6:0], p[7]}; exp_q.push_back(p); end
    enable = 1'b1;
    wait_until(0, 50, "tick_wait", n);
    req("tick_to_awvalid", 32'(n), 32'(10));
    wait_steps(8, 200);
    enable = 1'b0;
    req("walk_steps", 32'(step_cnt), 32'(8));
    req("walk_err", 32'({err_mismatch, err_timeout, err_overrun}), 32'(0));
    tick1();
    req("walk_idle", 32'(busy), 32'(0));

    // 2: toggle to FE, count FF,00,01, toggle FE,01,FE
    mode = 2'b10; exp_q.push_back(8'hFE);
    enable = 1'b1; wait_steps(9, 100); enable = 1'b0;
    mode = 2'b01;
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    enable = 1'b1; wait_steps(12, 200); enable = 1'b0;
    mode = 2'b10;
    exp_q.push_back(8'hFE); exp_q.push_back(8'h01); exp_q.push_back(8'hFE);
    enable = 1'b1; wait_steps(15, 200); enable = 1'b0;
    req("modes_err", 32'({err_mismatch, err_timeout, err_overrun}), 32'(0));

    // 3: corrupted readback, sticky flag, clear, clear colliding with set
    mode = 2'b11; corrupt_once = 1'b1; exp_q.push_back(8'hFE);
    enable = 1'b1; wait_steps(16, 100); enable = 1'b0; corrupt_once = 1'b0;
    req("mm_set", 32'(err_mismatch), 32'(1));
    repeat (3) tick1();
    req("mm_sticky", 32'(err_mismatch), 32'(1));
    pulse_clr();
    req("mm_clr", 32'(err_mismatch), 32'(0));
    corrupt_once = 1'b1; exp_q.push_back(8'hFE);
    enable = 1'b1;
    wait_until(3, 100, "r_hs_wait", n);
    pulse_clr();
    enable = 1'b0; corrupt_once = 1'b0;
    req("mm_clr_vs_set", 32'(err_mismatch), 32'(1));
    wait_steps(17, 10);
    pulse_clr();
    req("mm_clr2", 32'(err_mismatch), 32'(0));

    // 4: awready 3 cycles late, wready immediate
    aw_delay = 3; exp_q.push_back(8'hFE);
    enable = 1'b1;
    wait_until(0, 50, "aw_wait", n);
    na = 0; nw = 0; nb = 0; n = 0;
    while (step_cnt != 16'd18 && n < 30) begin
      na += 32'(awvalid); nw += 32'(wvalid); nb += 32'(bready);
      tick1(); n++;
    end
    enable = 1'b0; aw_delay = 0;
    req("aw_cycles", 32'(na), 32'(4));
    req("w_cycles", 32'(nw), 32'(1));
    req("b_cycles", 32'(nb), 32'(1));
    req("awdly_step", 32'(step_cnt), 32'(18));
    req("awdly_err", 32'({err_mismatch, err_timeout, err_overrun}), 32'(0));

    // 5: period 0 with AR stalled: timeout after 255 waits, overrun from back-to-back ticks
    period = 24'd0; ar_block = 1'b1; exp_q.push_back(8'hFE);
    enable = 1'b1;
    wait_until(2, 50, "ar_wait", n);
    repeat (250) tick1();
    req("to_early", 32'(err_timeout), 32'(0));
    req("to_arvalid_early", 32'(arvalid), 32'(1));
    repeat (10) tick1();
    req("to_set", 32'(err_timeout), 32'(1));
    req("to_arvalid_held", 32'(arvalid), 32'(1));
    req("overrun_set", 32'(err_overrun), 32'(1));
    enable = 1'b0; ar_block = 1'b0;
    wait_steps(19, 20);
    tick1();
    req("to_idle", 32'(busy), 32'(0));
    pulse_clr();
    req("to_clr", 32'({err_mismatch, err_timeout, err_overrun}), 32'(0));

    // 6: enable dropped during WRESP, then reset mid-RD
    period = 24'd10; exp_q.push_back(8'hFE);
    enable = 1'b1;
    wait_until(1, 50, "b_wait", n);
    enable = 1'b0;
    wait_steps(20, 20);
    req("en_low_step", 32'(step_cnt), 32'(20));
    req("en_low_idle", 32'(busy), 32'(0));
    na = 0;
    repeat (30) begin na += 32'(awvalid); tick1(); end
    req("en_low_no_aw", 32'(na), 32'(0));
    ar_block = 1'b1; exp_q.push_back(8'hFE);
    enable = 1'b1;
    wait_until(2, 50, "ar_wait2", n);
    rst_n = 1'b0;
    tick1();
    req("rst_mid_handshake", 32'({awvalid, wvalid, bready, arvalid, rready, busy}), 32'(0));
    req("rst_mid_step", 32'(step_cnt), 32'(0));
    req("rst_mid_err", 32'({err_mismatch, err_timeout, err_overrun}), 32'(0));
    ar_block = 1'b0; enable = 1'b0; rst_n = 1'b1;

    repeat (3) tick1();
    req("sb_drained", 32'(exp_q.size()), 32'(0));
    repeat (2) tick1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
